// File: rtl/mcu_sram_pkg.sv
// Shared types and sizing constants for the MCU SRAM controller slice.
package mcu_sram_pkg;

   localparam int AW  = 12;
   localparam int DW  = 32;
   localparam int WAW = 10;
   localparam int BW  = DW / 8;

   typedef enum logic [1:0] {
      IDLE,
      RD_CAP,
      RMW_WR,
      RESP
   } state_t;

endpackage

// File: rtl/mcu_sram_be_merge.sv
// Per-byte merge: each enabled byte takes the new data, the rest keep the old data.
module mcu_sram_be_merge
   import mcu_sram_pkg::*;
#(
   parameter int DW = mcu_sram_pkg::DW
) (
   input  logic [DW-1:0]   old_i,
   input  logic [DW-1:0]   new_i,
   input  logic [DW/8-1:0] be_i,
   output logic [DW-1:0]   merged_o
);

   for (genvar i = 0; i < DW / 8; i++) begin : g_byte
      assign merged_o[8*i +: 8] = be_i[i] ? new_i[8*i +: 8] : old_i[8*i +: 8];
   end

endmodule

// File: rtl/mcu_sram_ctrl.sv
// Single-outstanding request/response bridge to a one-port synchronous SRAM,
// with read-modify-write for partial byte-enable writes.
module mcu_sram_ctrl
   import mcu_sram_pkg::*;
#(
   parameter int AW  = mcu_sram_pkg::AW,
   parameter int DW  = mcu_sram_pkg::DW,
   parameter int WAW = mcu_sram_pkg::WAW
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [AW-1:0]   req_addr,
   input  logic [DW-1:0]   req_wdata,
   input  logic [DW/8-1:0] req_be,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [DW-1:0]   rsp_rdata,
   output logic            rsp_err,
   output logic            sram_we,
   output logic [WAW-1:0]  sram_addr,
   output logic [DW-1:0]   sram_din,
   input  logic [DW-1:0]   sram_dout
);

   localparam logic [DW/8-1:0] BE_FULL = '1;

   state_t           state_q;
   logic [WAW-1:0]   addr_q;
   logic [DW-1:0]    wdata_q;
   logic [DW/8-1:0]  be_q;
   logic [DW-1:0]    rdata_q;
   logic             err_q;

   logic             inIdle;
   logic             handshake;
   logic             aligned;
   logic [DW-1:0]    merged;

   assign inIdle    = (state_q == IDLE);
   assign aligned   = (req_addr[1:0] == 2'b00);
   assign req_ready = inIdle && rst_n;
   assign handshake = req_valid && req_ready;

   mcu_sram_be_merge #(.DW(DW)) u_merge (
      .old_i    (sram_dout),
      .new_i    (wdata_q),
      .be_i     (be_q),
      .merged_o (merged)
   );

   // In IDLE the SRAM sees the live request so reads start on the acceptance edge.
   assign sram_addr = inIdle ? req_addr[AW-1:2] : addr_q;
   assign sram_din  = inIdle ? req_wdata : merged;
   assign sram_we   = rst_n &&
                      ((handshake && req_we && (req_be == BE_FULL) && aligned) ||
                       (state_q == RMW_WR));

   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (handshake) begin
                  addr_q  <= req_addr[AW-1:2];
                  wdata_q <= req_wdata;
                  be_q    <= req_be;
                  rdata_q <= '0;
                  err_q   <= !aligned;
                  if (!aligned) begin
                     state_q <= RESP;
                  end else if (!req_we) begin
                     state_q <= RD_CAP;
                  end else if ((req_be == BE_FULL) || (req_be == '0)) begin
                     state_q <= RESP;
                  end else begin
                     state_q <= RMW_WR;
                  end
               end
            end
            RD_CAP: begin
               rdata_q <= sram_dout;
               err_q   <= 1'b0;
               state_q <= RESP;
            end
            RMW_WR: begin
               rdata_q <= '0;
               err_q   <= 1'b0;
               state_q <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mcu_sram_ctrl.sv
// Directed bench for mcu_sram_ctrl with a behavioural SRAM and a response scoreboard.
module tb_mcu_sram_ctrl;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } expRsp_t;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [11:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        sram_we;
   logic [9:0]  sram_addr;
   logic [31:0] sram_din;
   logic [31:0] sram_dout;

   logic [31:0] mem [1024];
   expRsp_t     expQ [$];
   int          checks;
   int          errors;
   int          weCount;
   int          weBefore;

   mcu_sram_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .sram_we   (sram_we),
      .sram_addr (sram_addr),
      .sram_din  (sram_din),
      .sram_dout (sram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous single-port SRAM: read data appears the cycle after a read edge.
   always @(posedge clk) begin
      if (sram_we === 1'b1) begin
         mem[sram_addr] <= sram_din;
         weCount++;
      end else begin
         sram_dout <= mem[sram_addr];
      end
   end

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input logic [31:0] expRdata, input logic expErr);
      @(negedge clk);
      checkVal("reqReadyBeforeAccept", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      expQ.push_back('{rdata: expRdata, err: expErr});
   endtask

   task automatic checkOutput(input string tag, input int expLat);
      int lat;
      expRsp_t e;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkVal({tag, "_latency"}, lat, expLat);
      checkVal({tag, "_queueDepth"}, expQ.size(), 32'd1);
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkVal({tag, "_rdata"}, rsp_rdata, e.rdata);
         checkVal({tag, "_err"}, {31'b0, rsp_err}, {31'b0, e.err});
      end
   endtask

   task automatic releaseResponse(input string tag);
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      checkVal({tag, "_rspValidAfterHandshake"}, {31'b0, rsp_valid}, 32'd0);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      weCount   = 0;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_be    = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'hA5A50000 | i;
      mem[4]   = 32'h11223344;
      mem[8]   = 32'h55555555;
      mem[255] = 32'hCAFEF00D;

      repeat (2) @(posedge clk);
      #1;
      checkVal("resetReqReady", {31'b0, req_ready}, 32'd0);
      checkVal("resetSramWe", {31'b0, sram_we}, 32'd0);
      checkVal("resetRspValid", {31'b0, rsp_valid}, 32'd0);
      checkVal("resetRdata", rsp_rdata, 32'd0);
      checkVal("resetErr", {31'b0, rsp_err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Full write then read back.
      applyStimulus(1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0);
      checkOutput("fullWrite", 1);
      releaseResponse("fullWrite");
      checkVal("fullWriteMem", mem[1], 32'hDEADBEEF);
      applyStimulus(1'b0, 12'h004, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
      checkOutput("readBack", 2);
      releaseResponse("readBack");

      // Partial write merges with the old word.
      applyStimulus(1'b1, 12'h010, 32'hAABBCCDD, 4'b0101, 32'd0, 1'b0);
      checkOutput("partialWrite", 2);
      releaseResponse("partialWrite");
      applyStimulus(1'b0, 12'h010, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
      checkOutput("partialRead", 2);
      releaseResponse("partialRead");

      // Misaligned read and misaligned full write must not touch memory.
      weBefore = weCount;
      applyStimulus(1'b0, 12'h006, 32'h0, 4'h0, 32'd0, 1'b1);
      checkOutput("misalignRead", 1);
      releaseResponse("misalignRead");
      applyStimulus(1'b1, 12'h00A, 32'h12345678, 4'hF, 32'd0, 1'b1);
      checkOutput("misalignWrite", 1);
      releaseResponse("misalignWrite");
      checkVal("misalignWeCount", weCount, weBefore);
      checkVal("misalignMem1", mem[1], 32'hDEADBEEF);
      checkVal("misalignMem2", mem[2], 32'hA5A50002);

      // Response held for five cycles stays stable; next request right after handshake.
      applyStimulus(1'b0, 12'h004, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
      checkOutput("holdRead", 2);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         checkVal("holdRspValid", {31'b0, rsp_valid}, 32'd1);
         checkVal("holdRdata", rsp_rdata, 32'hDEADBEEF);
         checkVal("holdErr", {31'b0, rsp_err}, 32'd0);
         checkVal("holdReqReady", {31'b0, req_ready}, 32'd0);
      end
      releaseResponse("holdRead");
      applyStimulus(1'b0, 12'h3FC, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
      checkOutput("backToBack", 2);
      releaseResponse("backToBack");

      // Reset during RMW_WR aborts the write and drops the response.
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 12'h020;
      req_wdata = 32'h000000EE;
      req_be    = 4'b0001;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      rst_n     = 1'b0;
      #1;
      checkVal("abortSramWe", {31'b0, sram_we}, 32'd0);
      checkVal("abortReqReady", {31'b0, req_ready}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         checkVal("abortNoRsp", {31'b0, rsp_valid}, 32'd0);
      end
      checkVal("abortMem", mem[8], 32'h55555555);
      applyStimulus(1'b0, 12'h020, 32'h0, 4'h0, 32'h55555555, 1'b0);
      checkOutput("abortReread", 2);
      releaseResponse("abortReread");

      // Zero byte-enable write is a no-op with a one-edge response.
      weBefore = weCount;
      applyStimulus(1'b1, 12'h3FC, 32'h99999999, 4'h0, 32'd0, 1'b0);
      checkOutput("beZeroWrite", 1);
      releaseResponse("beZeroWrite");
      checkVal("beZeroWeCount", weCount, weBefore);
      checkVal("beZeroMem", mem[255], 32'hCAFEF00D);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mcu_sram_ctrl.md
MCU_SRAM_CTRL -- requirements
Module: mcu_sram_ctrl

Interface
REQ-001 Parameters SHALL be: AW = 12 (byte address width, 4 KB space); DW = 32 (data width); WAW = 10 (SRAM word address width).
REQ-002 clk  in  1  sole clock; every register is updated on its rising edge.
REQ-003 rst_n  in  1  reset; synchronous, active-low.
REQ-004 req_valid  in  1  request valid.
REQ-005 req_ready  out  1  request accepted when req_valid and req_ready are both high at a rising edge.
REQ-006 req_we  in  1  1 = write, 0 = read.
REQ-007 req_addr  in  12  byte address; bits [1:0] must be 0.
REQ-008 req_wdata  in  32  write data.
REQ-009 req_be  in  4  byte enables; bit i covers wdata[8i+7:8i].
REQ-010 rsp_valid  out  1  response valid; held until rsp_ready.
REQ-011 rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high at a rising edge.
REQ-012 rsp_rdata  out  32  read data; 0 for writes and errors.
REQ-013 rsp_err  out  1  misaligned access.
REQ-014 sram_we  out  1  to SRAM write enable.
REQ-015 sram_addr  out  10  to SRAM word address.
REQ-016 sram_din  out  32  to SRAM write data.
REQ-017 sram_dout  in  32  from SRAM; valid the cycle after a read edge (sram_we = 0); unchanged after write edges.

Function
REQ-018 States SHALL be IDLE, RD_CAP, RMW_WR and RESP; only one request is outstanding at a time.
REQ-019 req_ready = (state == IDLE) and rst_n.
REQ-020 In IDLE, the SRAM port is driven combinationally from the request: sram_addr = req_addr[11:2]; sram_din = req_wdata; sram_we = handshake and req_we and (req_be == 4'hF) and aligned.
REQ-021 Aligned read accepted at edge k: the SRAM reads at edge k; the FSM goes IDLE->RD_CAP; at edge k+1, rsp_rdata <= sram_dout, rsp_err <= 0, and the FSM goes to RESP.
REQ-022 Full write (be = F) accepted at edge k: the SRAM writes at edge k; the FSM goes IDLE->RESP with rsp_rdata = 0.
REQ-023 Partial write (be not 0 and not F) accepted at edge k: the SRAM reads at edge k; the FSM goes IDLE->RMW_WR.
REQ-024 In RMW_WR: sram_we = 1; sram_addr = latched word address; sram_din = per-byte merge (be ? latched wdata : sram_dout). The write happens at edge k+1; the FSM then goes to RESP.
REQ-025 be = 0 write: no SRAM write (sram_we = 0); the FSM goes IDLE->RESP directly.
REQ-026 Misaligned request (addr[1:0] != 0), read or write: no SRAM write; the FSM goes IDLE->RESP with rsp_err = 1 and rsp_rdata = 0.
REQ-027 rsp_valid = (state == RESP); rsp_rdata and rsp_err are stable while in RESP; RESP->IDLE on rsp_ready.
REQ-028 Back-to-back: a new request is accepted no earlier than the cycle after the response handshake (no RESP->IDLE bypass).
REQ-029 Outside IDLE and RMW_WR, sram_we SHALL be 0; sram_addr holds the latched word address.
REQ-030 Minimum latency, acceptance edge to rsp_valid high: read 2 edges; partial write 2 edges; full/be=0/error 1 edge.

Reset
REQ-031 While rst_n = 0 at an edge: state <= IDLE; rsp_valid, rsp_err <= 0; rsp_rdata <= 0; latched address/data/be <= 0.
REQ-032 While rst_n = 0, sram_we and req_ready SHALL be forced to 0 combinationally.
REQ-033 Reset mid-operation aborts the operation: an RMW partial write is not performed (SRAM contents unchanged), and no response is issued for the aborted request.

Structure
REQ-034 Package mcu_sram_pkg SHALL hold the state enum (IDLE, RD_CAP, RMW_WR, RESP), AW/DW/WAW constants, and the BE width (DW/8).
REQ-035 Byte merge SHALL be one combinational sub-module, mcu_sram_be_merge (old, new, be -> merged), instantiated once.
REQ-036 The SRAM itself is not instantiated inside the block; the bench and top level connect it.

Verification
REQ-037 Full write 0x004 <= 0xDEADBEEF, then read 0x004 -> rsp_valid 1 edge after the write, then 2 edges after the read; rdata = 0xDEADBEEF; err = 0.
REQ-038 Word at 0x010 = 0x11223344; write be = 4'b0101, wdata = 0xAABBCCDD; then read -> rdata = 0x11BB33DD; the write response arrives 2 edges after acceptance.
REQ-039 Read at 0x006 -> rsp_err = 1, rdata = 0; sram_we never high; memory unchanged.
REQ-040 Hold rsp_ready = 0 for 5 cycles after a read -> rsp_valid, rdata and err stay stable; req_ready = 0 throughout; the next request is accepted the cycle after the handshake.
REQ-041 Assert rst_n = 0 in RMW_WR for a be = 4'b0001 write to 0x020 (old 0x55555555) -> no response; re-read returns 0x55555555.
REQ-042 be = 0 write to 0x3FC -> response after 1 edge, err = 0; sram_we never high; contents unchanged.
